// File: rtl/frame_column_loader.sv
// Column configuration loader: gathers one frame word per tile row, then
// pulses the one-hot frame strobe for a single cycle followed by a gap cycle.
module frame_column_loader #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows = 4,
    localparam int AW = $clog2(MaxFramesPerCol)
) (
    input  logic                                 CLK,
    input  logic                                 resetn,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic                                 cfg_first,
    input  logic [AW-1:0]                        cfg_addr,
    input  logic [FrameBitsPerRow-1:0]           cfg_data,
    input  logic                                 err_clr,
    output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]           FrameStrobe,
    output logic                                 busy,
    output logic                                 err
);

    localparam int CW = $clog2(NumRows + 1);
    localparam logic [AW:0] MAX_ADDR = (AW+1)'(MaxFramesPerCol);
    localparam logic [CW-1:0] LAST_ROW = CW'(NumRows - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STROBE,
        GAP
    } state_e;

    state_e                               state_q;
    logic [AW-1:0]                        addr_q;
    logic [CW-1:0]                        cnt_q;
    logic [NumRows*FrameBitsPerRow-1:0]   data_q;
    logic [MaxFramesPerCol-1:0]           strobe_q;
    logic                                 err_q;
    logic                                 addr_ok;

    function automatic logic [MaxFramesPerCol-1:0] onehot(
        input logic [AW-1:0] a
    );
        return MaxFramesPerCol'(1) << a;
    endfunction

    assign cfg_ready   = (state_q == IDLE) || (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign addr_ok     = {1'b0, cfg_addr} < MAX_ADDR;
    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign err         = err_q;

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            err_q    <= 1'b0;
        end else begin
            // Clear first so an error raised below in the same cycle wins.
            if (err_clr) begin
                err_q <= 1'b0;
            end
            unique case (state_q)
                IDLE, LOAD: begin
                    if (cfg_valid) begin
                        if (cfg_first) begin
                            if (state_q == LOAD) begin
                                err_q <= 1'b1;
                            end
                            if (addr_ok) begin
                                addr_q <= cfg_addr;
                                data_q[FrameBitsPerRow-1:0] <= cfg_data;
                                if (NumRows == 1) begin
                                    cnt_q    <= '0;
                                    strobe_q <= onehot(cfg_addr);
                                    state_q  <= STROBE;
                                end else begin
                                    cnt_q   <= CW'(1);
                                    state_q <= LOAD;
                                end
                            end else begin
                                err_q   <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= IDLE;
                            end
                        end else if (state_q == IDLE) begin
                            err_q <= 1'b1;
                        end else begin
                            for (int r = 0; r < NumRows; r++) begin
                                if (cnt_q == CW'(r)) begin
                                    data_q[r*FrameBitsPerRow +: FrameBitsPerRow]
                                        <= cfg_data;
                                end
                            end
                            cnt_q <= cnt_q + CW'(1);
                            if (cnt_q == LAST_ROW) begin
                                strobe_q <= onehot(addr_q);
                                state_q  <= STROBE;
                            end
                        end
                    end
                end
                STROBE: begin
                    strobe_q <= '0;
                    state_q  <= GAP;
                end
                GAP: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    strobe_q <= '0;
                    cnt_q    <= '0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_column_loader.sv
// Scoreboard bench for frame_column_loader: expected strobes/data are queued
// as frames are driven and matched when the strobe appears.
module tb_frame_column_loader;

    localparam int MF = 20;
    localparam int FB = 32;
    localparam int NR = 4;
    localparam int AW = 5;
    localparam int DW = NR * FB;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_first = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [FB-1:0] cfg_data = '0;
    logic          err_clr = 1'b0;
    logic          cfg_ready;
    logic [DW-1:0] FrameData;
    logic [MF-1:0] FrameStrobe;
    logic          busy;
    logic          err;

    frame_column_loader #(
        .MaxFramesPerCol(MF),
        .FrameBitsPerRow(FB),
        .NumRows(NR)
    ) dut (
        .CLK(CLK),
        .resetn(resetn),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_first(cfg_first),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .err_clr(err_clr),
        .FrameData(FrameData),
        .FrameStrobe(FrameStrobe),
        .busy(busy),
        .err(err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [MF-1:0] stb;
        logic [DW-1:0] data;
        int            acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [MF-1:0] prev_stb = '0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            if (prev_stb != '0) begin
                check("stb_one_cycle", 128'(FrameStrobe), 128'(0));
            end else if (sb.size() == 0) begin
                check("stb_unexpected", 128'(FrameStrobe), 128'(0));
            end else begin
                mon_e = sb.pop_front();
                check("sb_strobe", 128'(FrameStrobe), 128'(mon_e.stb));
                check("sb_data", 128'(FrameData), 128'(mon_e.data));
                check("sb_latency", 128'(cyc), 128'(mon_e.acc + 1));
            end
        end
        prev_stb = FrameStrobe;
    end

    task automatic send(input logic f, input logic [AW-1:0] a,
                        input logic [FB-1:0] d, output int acc);
        int n;
        @(negedge CLK);
        cfg_valid = 1'b1;
        cfg_first = f;
        cfg_addr  = a;
        cfg_data  = d;
        n = 0;
        while (!cfg_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!cfg_ready) check("ready_timeout", 128'(cfg_ready), 128'(1));
        acc = cyc;
        @(posedge CLK);
        #1;
        cfg_valid = 1'b0;
        cfg_first = 1'b0;
    endtask

    task automatic frame(input logic [AW-1:0] a, input logic [DW-1:0] w,
                         input int gap, output int first_acc,
                         output int last_acc);
        int t;
        exp_t e;
        t = 0;
        first_acc = 0;
        for (int i = 0; i < NR; i++) begin
            if (i > 0) repeat (gap) @(negedge CLK);
            send(i == 0, a, w[i*FB +: FB], t);
            if (i == 0) first_acc = t;
        end
        last_acc = t;
        e.stb  = MF'(1) << a;
        e.data = w;
        e.acc  = t;
        sb.push_back(e);
    endtask

    task automatic pulse_clr();
        @(negedge CLK);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int fa, la, f2, l2, t;
        logic [DW-1:0] w, last_w;

        resetn = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_strobe", 128'(FrameStrobe), 128'(0));
        check("rst_data", 128'(FrameData), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        @(posedge CLK);
        #1;
        resetn = 1'b1;
        @(negedge CLK);
        check("rst_ready", 128'(cfg_ready), 128'(1));

        // Normal frame, addr 3.
        w = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
        frame(5'd3, w, 0, fa, la);
        last_w = w;
        @(negedge CLK);
        check("n1_strobe", 128'(FrameStrobe), 128'(20'h00008));
        check("n1_ready", 128'(cfg_ready), 128'(0));
        check("n1_busy", 128'(busy), 128'(1));
        @(negedge CLK);
        check("n2_ready", 128'(cfg_ready), 128'(0));
        check("n2_strobe", 128'(FrameStrobe), 128'(0));
        check("n2_data", 128'(FrameData), 128'(last_w));
        @(negedge CLK);
        check("n3_ready", 128'(cfg_ready), 128'(1));
        check("n3_busy", 128'(busy), 128'(0));
        check("n3_err", 128'(err), 128'(0));

        // Bad address, then orphan word.
        send(1'b1, 5'd25, 32'hDEAD_BEEF, t);
        @(negedge CLK);
        check("bad_err", 128'(err), 128'(1));
        check("bad_data", 128'(FrameData), 128'(last_w));
        check("bad_busy", 128'(busy), 128'(0));
        send(1'b0, 5'd3, 32'h0BAD_0BAD, t);
        @(negedge CLK);
        check("orph_err", 128'(err), 128'(1));
        check("orph_data", 128'(FrameData), 128'(last_w));
        pulse_clr();
        check("clr_err", 128'(err), 128'(0));

        // err_clr coinciding with a new error: set wins.
        err_clr = 1'b1;
        send(1'b0, 5'd1, 32'h1234_5678, t);
        err_clr = 1'b0;
        @(negedge CLK);
        check("setwins_err", 128'(err), 128'(1));
        pulse_clr();
        check("clr2_err", 128'(err), 128'(0));

        // Restart mid-LOAD: addr 5 abandoned, addr 7 completes.
        send(1'b1, 5'd5, 32'hB0B0_B0B0, t);
        send(1'b0, 5'd5, 32'hB1B1_B1B1, t);
        w = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
        frame(5'd7, w, 0, fa, la);
        last_w = w;
        @(negedge CLK);
        check("rs_err", 128'(err), 128'(1));
        check("rs_strobe", 128'(FrameStrobe), 128'(20'h00080));
        pulse_clr();

        // Stalled source, then a waiting next frame.
        w = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
        frame(5'd10, w, 2, fa, la);
        @(negedge CLK);
        cfg_valid = 1'b1;
        cfg_first = 1'b1;
        cfg_addr  = 5'd2;
        cfg_data  = 32'hE0E0_0000;
        check("stb_ready_v", 128'(cfg_ready), 128'(0));
        @(negedge CLK);
        check("gap_ready_v", 128'(cfg_ready), 128'(0));
        w = {32'hE3E3_0003, 32'hE2E2_0002, 32'hE1E1_0001, 32'hE0E0_0000};
        frame(5'd2, w, 0, f2, l2);
        check("throughput", 128'(f2 - la), 128'(3));

        // Back-to-back random frames.
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < NR; r++) w[r*FB +: FB] = $urandom;
            frame(AW'($urandom_range(0, MF - 1)), w, 0, fa, la);
        end

        // Reset while strobing.
        w = {32'hF3F3_0003, 32'hF2F2_0002, 32'hF1F1_0001, 32'hF0F0_0000};
        frame(5'd12, w, 0, fa, la);
        resetn = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("rstb_strobe", 128'(FrameStrobe), 128'(0));
        check("rstb_data", 128'(FrameData), 128'(0));
        check("rstb_busy", 128'(busy), 128'(0));
        @(posedge CLK);
        #1;
        resetn = 1'b1;
        w = {32'h9393_0003, 32'h9292_0002, 32'h9191_0001, 32'h9090_0000};
        frame(5'd19, w, 0, fa, la);
        @(negedge CLK);
        check("a19_strobe", 128'(FrameStrobe), 128'(20'h80000));
        check("a19_data", 128'(FrameData), 128'(w));

        repeat (4) @(negedge CLK);
        check("sb_empty", 128'(sb.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
